// File: rtl/ctrl_pkg.sv
// rtl/ctrl_pkg.sv - shared encodings for the multi-cycle RV32I controller
package ctrl_pkg;

   typedef enum logic [3:0] {
      S_FETCH,
      S_DECODE,
      S_MEMADR,
      S_MEMRD,
      S_MEMWB,
      S_MEMWR,
      S_EXECR,
      S_EXECI,
      S_ALUWB,
      S_BRANCH,
      S_JALR,
      S_LINK,
      S_LUI,
      S_TRAP
   } state_t;

   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_REG    = 7'b0110011;
   localparam logic [6:0] OP_IMM    = 7'b0010011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_JALR   = 7'b1100111;
   localparam logic [6:0] OP_LUI    = 7'b0110111;
   localparam logic [6:0] OP_AUIPC  = 7'b0010111;

   localparam logic [2:0] IMM_LOAD   = 3'b000;
   localparam logic [2:0] IMM_OPIMM  = 3'b001;
   localparam logic [2:0] IMM_SHIFT  = 3'b010;
   localparam logic [2:0] IMM_STORE  = 3'b011;
   localparam logic [2:0] IMM_UPPER  = 3'b100;
   localparam logic [2:0] IMM_BRANCH = 3'b101;
   localparam logic [2:0] IMM_JALR   = 3'b110;
   localparam logic [2:0] IMM_JAL    = 3'b111;

   localparam logic [1:0] SRCA_PC    = 2'b00;
   localparam logic [1:0] SRCA_OLDPC = 2'b01;
   localparam logic [1:0] SRCA_RS1   = 2'b10;
   localparam logic [1:0] SRCA_ZERO  = 2'b11;

   localparam logic [1:0] SRCB_RS2   = 2'b00;
   localparam logic [1:0] SRCB_IMM   = 2'b01;
   localparam logic [1:0] SRCB_FOUR  = 2'b10;

   localparam logic [1:0] ALU_ADD    = 2'b00;
   localparam logic [1:0] ALU_SUB    = 2'b01;
   localparam logic [1:0] ALU_FUNCT  = 2'b10;

   localparam logic [1:0] RES_ALUOUT = 2'b00;
   localparam logic [1:0] RES_MEM    = 2'b01;
   localparam logic [1:0] RES_ALU    = 2'b10;

endpackage

// File: rtl/imm_sel.sv
// rtl/imm_sel.sv - opcode/funct3 to immediate-extender format
import ctrl_pkg::*;

module imm_sel (
   input  logic [6:0] i_opcode,
   input  logic [2:0] i_funct3,
   output logic [2:0] o_immSrc
);

   always_comb begin
      o_immSrc = IMM_LOAD;
      case (i_opcode)
         OP_LOAD:   o_immSrc = IMM_LOAD;
         OP_IMM:    o_immSrc = (i_funct3 == 3'b001 || i_funct3 == 3'b101) ? IMM_SHIFT : IMM_OPIMM;
         OP_STORE:  o_immSrc = IMM_STORE;
         OP_LUI,
         OP_AUIPC:  o_immSrc = IMM_UPPER;
         OP_BRANCH: o_immSrc = IMM_BRANCH;
         OP_JALR:   o_immSrc = IMM_JALR;
         OP_JAL:    o_immSrc = IMM_JAL;
         default:   o_immSrc = IMM_LOAD;
      endcase
   end

endmodule

// File: rtl/mc_controller.sv
// rtl/mc_controller.sv - multi-cycle RV32I main controller FSM
import ctrl_pkg::*;

module mc_controller (
   input  logic       i_clk,
   input  logic       i_rst,
   input  logic [6:0] i_opcode,
   input  logic [2:0] i_funct3,
   input  logic       i_branchTaken,
   input  logic       i_memAck,
   output logic       o_memReq,
   output logic       o_memWrite,
   output logic       o_adrSrc,
   output logic       o_irWrite,
   output logic       o_pcWrite,
   output logic       o_pcSrc,
   output logic       o_regWrite,
   output logic [1:0] o_aluSrcA,
   output logic [1:0] o_aluSrcB,
   output logic [1:0] o_aluOp,
   output logic [1:0] o_resultSrc,
   output logic [2:0] o_immSrc,
   output logic       o_illegal
);

   state_t     state, state_next;
   logic [2:0] imm_fmt;
   logic       mem_req, mem_write, ir_write, pc_write, reg_write;

   imm_sel u_imm_sel (
      .i_opcode (i_opcode),
      .i_funct3 (i_funct3),
      .o_immSrc (imm_fmt)
   );

   always_ff @(posedge i_clk) begin
      if (i_rst) state <= S_FETCH;
      else       state <= state_next;
   end

   always_comb begin
      state_next = state;
      case (state)
         S_FETCH:  if (i_memAck) state_next = S_DECODE;
         S_DECODE: begin
            case (i_opcode)
               OP_LOAD, OP_STORE: state_next = S_MEMADR;
               OP_REG:            state_next = S_EXECR;
               OP_IMM:            state_next = S_EXECI;
               OP_BRANCH:         state_next = S_BRANCH;
               OP_JAL:            state_next = S_LINK;
               OP_JALR:           state_next = S_JALR;
               OP_LUI:            state_next = S_LUI;
               OP_AUIPC:          state_next = S_ALUWB;
               default:           state_next = S_TRAP;
            endcase
         end
         S_MEMADR: state_next = (i_opcode == OP_STORE) ? S_MEMWR : S_MEMRD;
         S_MEMRD:  if (i_memAck) state_next = S_MEMWB;
         S_MEMWB:  state_next = S_FETCH;
         S_MEMWR:  if (i_memAck) state_next = S_FETCH;
         S_EXECR,
         S_EXECI,
         S_LUI:    state_next = S_ALUWB;
         S_ALUWB,
         S_BRANCH,
         S_LINK:   state_next = S_FETCH;
         S_JALR:   state_next = S_LINK;
         S_TRAP:   state_next = S_TRAP;
         default:  state_next = S_TRAP;
      endcase
   end

   always_comb begin
      mem_req     = 1'b0;
      mem_write   = 1'b0;
      ir_write    = 1'b0;
      pc_write    = 1'b0;
      reg_write   = 1'b0;
      o_adrSrc    = 1'b0;
      o_pcSrc     = 1'b0;
      o_aluSrcA   = SRCA_PC;
      o_aluSrcB   = SRCB_RS2;
      o_aluOp     = ALU_ADD;
      o_resultSrc = RES_ALUOUT;
      o_illegal   = 1'b0;
      case (state)
         S_FETCH: begin
            mem_req     = 1'b1;
            ir_write    = i_memAck;
            pc_write    = i_memAck;
            o_aluSrcB   = SRCB_FOUR;
            o_resultSrc = RES_ALU;
         end
         S_DECODE: begin
            o_aluSrcA = SRCA_OLDPC;
            o_aluSrcB = SRCB_IMM;
         end
         S_MEMADR, S_JALR: begin
            o_aluSrcA = SRCA_RS1;
            o_aluSrcB = SRCB_IMM;
         end
         S_MEMRD: begin
            mem_req  = 1'b1;
            o_adrSrc = 1'b1;
         end
         S_MEMWB: begin
            reg_write   = 1'b1;
            o_resultSrc = RES_MEM;
         end
         S_MEMWR: begin
            mem_req   = 1'b1;
            mem_write = 1'b1;
            o_adrSrc  = 1'b1;
         end
         S_EXECR: begin
            o_aluSrcA = SRCA_RS1;
            o_aluOp   = ALU_FUNCT;
         end
         S_EXECI: begin
            o_aluSrcA = SRCA_RS1;
            o_aluSrcB = SRCB_IMM;
            o_aluOp   = ALU_FUNCT;
         end
         S_ALUWB:  reg_write = 1'b1;
         S_BRANCH: begin
            o_aluSrcA = SRCA_RS1;
            o_aluOp   = ALU_SUB;
            pc_write  = i_branchTaken;
            o_pcSrc   = 1'b1;
         end
         S_LINK: begin
            o_aluSrcA   = SRCA_OLDPC;
            o_aluSrcB   = SRCB_FOUR;
            o_resultSrc = RES_ALU;
            reg_write   = 1'b1;
            pc_write    = 1'b1;
            o_pcSrc     = 1'b1;
         end
         S_LUI: begin
            o_aluSrcA = SRCA_ZERO;
            o_aluSrcB = SRCB_IMM;
         end
         S_TRAP:  o_illegal = 1'b1;
         default: o_illegal = 1'b1;
      endcase
   end

   // Strobes are held low for the whole reset cycle so an abandoned request cannot glitch.
   assign o_memReq   = mem_req   & ~i_rst;
   assign o_memWrite = mem_write & ~i_rst;
   assign o_irWrite  = ir_write  & ~i_rst;
   assign o_pcWrite  = pc_write  & ~i_rst;
   assign o_regWrite = reg_write & ~i_rst;
   assign o_immSrc   = (state == S_FETCH) ? IMM_LOAD : imm_fmt;

endmodule
